// File: rtl/mux8_rr_sched.sv
// mux8_rr_sched: round-robin scheduler owning the select lines of an 8:1 bit mux.
// Grants persist while the owner keeps requesting, but are cut after MAX_HOLD
// cycles when another requester is waiting. y returns the selected data bit.
module mux8_rr_sched #(
    parameter int MAX_HOLD = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] req,
    input  logic [7:0] d,
    output logic [2:0] sel,
    output logic [7:0] gnt,
    output logic       gnt_valid,
    output logic       y
);

    localparam logic [3:0] HOLD_LIMIT = 4'(MAX_HOLD - 1);

    typedef enum logic {
        IDLE,
        GRANT
    } state_t;

    state_t     state, state_nxt;
    logic [2:0] ptr, ptr_nxt;
    logic [3:0] hcnt, hcnt_nxt;
    logic [2:0] sel_nxt;
    logic [7:0] gnt_nxt;
    logic       gnt_valid_nxt;

    logic [7:0] owner_mask;
    logic       others;
    logic       release_now;
    logic [7:0] arb_mask;
    logic [2:0] arb_start;
    logic [3:0] pick;

    // Returns {found, index} of the first set bit of mask scanning start, start+1, ... mod 8.
    function automatic logic [3:0] rr_pick(input logic [7:0] mask, input logic [2:0] start);
        logic [3:0] res;
        logic [2:0] idx;
        res = 4'b0000;
        for (int k = 7; k >= 0; k--) begin
            idx = start + 3'(k);
            if (mask[idx]) begin
                res = {1'b1, idx};
            end
        end
        return res;
    endfunction

    assign owner_mask  = 8'b0000_0001 << sel;
    assign others      = |(req & ~owner_mask);
    assign release_now = !req[sel] || ((hcnt >= HOLD_LIMIT) && others);
    assign pick        = rr_pick(arb_mask, arb_start);

    // Choose which requesters are eligible and where the round-robin scan begins.
    always_comb begin
        arb_mask  = req;
        arb_start = ptr;
        if (state == GRANT) begin
            arb_mask  = (req & ~owner_mask) | ((req[sel] && !others) ? owner_mask : 8'h00);
            arb_start = sel + 3'd1;
        end
    end

    // Next-state logic: start, hold, hand over or drop the grant.
    always_comb begin
        state_nxt     = state;
        ptr_nxt       = ptr;
        hcnt_nxt      = hcnt;
        sel_nxt       = sel;
        gnt_nxt       = gnt;
        gnt_valid_nxt = gnt_valid;
        case (state)
            IDLE: begin
                if (pick[3]) begin
                    state_nxt     = GRANT;
                    sel_nxt       = pick[2:0];
                    gnt_nxt       = 8'b0000_0001 << pick[2:0];
                    gnt_valid_nxt = 1'b1;
                    ptr_nxt       = pick[2:0] + 3'd1;
                    hcnt_nxt      = 4'd0;
                end
            end
            GRANT: begin
                if (!release_now) begin
                    hcnt_nxt = (hcnt == 4'd15) ? 4'd15 : hcnt + 4'd1;
                end else if (pick[3]) begin
                    sel_nxt  = pick[2:0];
                    gnt_nxt  = 8'b0000_0001 << pick[2:0];
                    ptr_nxt  = pick[2:0] + 3'd1;
                    hcnt_nxt = 4'd0;
                end else begin
                    state_nxt     = IDLE;
                    gnt_nxt       = 8'h00;
                    gnt_valid_nxt = 1'b0;
                    hcnt_nxt      = 4'd0;
                end
            end
            default: begin
                state_nxt     = IDLE;
                gnt_nxt       = 8'h00;
                gnt_valid_nxt = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            ptr       <= 3'd0;
            hcnt      <= 4'd0;
            sel       <= 3'd0;
            gnt       <= 8'h00;
            gnt_valid <= 1'b0;
        end else begin
            state     <= state_nxt;
            ptr       <= ptr_nxt;
            hcnt      <= hcnt_nxt;
            sel       <= sel_nxt;
            gnt       <= gnt_nxt;
            gnt_valid <= gnt_valid_nxt;
        end
    end

    // Data path: selected bit, forced low when no grant is active.
    always_comb begin
        y = gnt_valid & d[sel];
    end

endmodule
